hack_cpu_ctrl: RTL
==================

# hack_cpu_ctrl

Multi-cycle Hack CPU control and register stage wrapped around the existing 16-bit Hack `alu`. It fetches an instruction from instruction memory and decodes the A/C instruction format. It drives the ALU control bits and operands, then consumes the ALU result and `zr`/`ng` flags to update the A, D and PC registers and to write data memory. Both memory ports use a req/ack handshake, so memory latency is not fixed.

## Interface
No parameters; data width fixed at 16, address width at 15.
Reset is asynchronous, active-low (`rst_n`). There is one clock (`clk`).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  15  fetch address (= PC)
- imem_rdata  in  16  instruction word, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- dmem_re  out  1  data read request
- dmem_we  out  1  data write request
- dmem_addr  out  15  data address
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid when dmem_ack=1
- dmem_ack  in  1  data access complete
- retire  out  1  one-cycle pulse per completed instruction
- pc  out  15  PC register (debug)
- a_reg  out  16  A register (debug)
- d_reg  out  16  D register (debug)

## Operation
- C-instruction fields:
  - IR[15]=1; IR[14:13] ignored.
  - IR[12]=a, selects ALU y: a=1 → M, a=0 → A.
  - IR[11:6] = zx,nx,zy,ny,f,no.
  - IR[5:3] = dest A,D,M.
  - IR[2:0] = jump lt,eq,gt.
- A-instruction (IR[15]=0): A ← {1'b0, IR[14:0]}.
- ALU x = D.
- Jump is taken if (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr).
- If taken, PC ← A value at instruction start. Otherwise PC ← PC+1 modulo 2^15, so 0x7FFF wraps to 0.
- A and D writes occur on the same edge in EXEC. The M write uses the A value from before the update; the M write address is latched at EXEC.
- State machine:
  - IDLE (reset state) → FETCH.
  - FETCH: imem_req=1. On imem_ack, latch IR → DECODE.
  - DECODE:
    - A-instruction: write A, PC+1, retire → FETCH.
    - C-instruction with a=1: → MREAD.
    - C-instruction with a=0: → EXEC.
  - MREAD: dmem_re=1, dmem_addr=A[14:0]. On dmem_ack, latch M register → EXEC.
  - EXEC: update A/D/PC.
    - If dest M: latch addr/wdata → MWRITE.
    - Otherwise: retire → FETCH.
  - MWRITE: dmem_we=1 with latched addr/wdata. On dmem_ack: retire → FETCH.
- Ack inputs are ignored in any state that is not requesting.
- Requests stay asserted and outputs stay stable until ack.

## Timing
- Reset values:
  - All outputs 0.
  - PC=0, A=0, D=0, IR=0, state IDLE.
- Reset is asynchronous, so requests drop immediately when reset asserts mid-transaction.
- The first imem_req rises on the first clock edge after rst_n deasserts.
- Ack is sampled on the rising edge and may arrive in the same cycle as the request.
- Minimum latency at zero wait:
  - A-instruction: 2 cycles (FETCH, DECODE).
  - C-instruction without M access: 3 cycles.
  - C-instruction reading M: 4 cycles.
  - C-instruction writing M: 4 cycles.
  - C-instruction reading and writing M: 5 cycles.
- retire is asserted in the final cycle of each instruction.
- The ALU is purely combinational; its result is consumed in EXEC in the same cycle.
- Outputs are state-decoded; IR, M register and write data are registered.

## Structure
- Shared package `hack_pkg`:
  - state enum (IDLE, FETCH, DECODE, MREAD, EXEC, MWRITE);
  - field bit-position constants;
  - ADDR_W=15, DATA_W=16.
- One sub-module: the existing `alu`, instantiated unchanged.
- Jump evaluation stays inline.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0, then release.
  - Required: all outputs 0 during reset; after release imem_req=1 and imem_addr=0.
- A-instruction then D=A:
  - Stimulus: 0x0005, then 0xEC10, with zero-wait ack.
  - Required: a_reg=5, d_reg=5, pc=2; retire pulses twice; total 5 cycles.
- Taken jump:
  - Stimulus: D=5, then 0x0064, then 0xE301 (D;JGT).
  - Required: pc=100.
  - Repeat with D=0. Required: pc increments.
- M write with wait states:
  - Stimulus: A=7, D=5, instruction 0xE7C8 (M=D+1); dmem_ack delayed 3 cycles.
  - Required: dmem_we held with dmem_addr=7 and dmem_wdata=6 until ack; retire pulses once.
- M read then negative jump:
  - Stimulus: 0xFC10 (D=M) with dmem_rdata=0x8000; then A=0x0010, then 0xE304 (D;JLT).
  - Required: d_reg=0x8000; pc=0x10.
- Reset during write:
  - Stimulus: assert rst_n=0 while in MWRITE.
  - Required: dmem_we drops immediately; PC/A/D return to 0; no retire.
- PC wrap:
  - Stimulus: non-jumping instruction at pc 0x7FFF.
  - Required: pc becomes 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control stage: datapath widths,
// FSM state encoding and instruction field bit positions.
package hack_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MREAD,
    EXEC,
    MWRITE
  } state_t;

  // Instruction word layout
  localparam int CI_BIT = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int A_BIT  = 12;  // ALU y select: 1 = M, 0 = A
  localparam int ZX_BIT = 11;
  localparam int NX_BIT = 10;
  localparam int ZY_BIT = 9;
  localparam int NY_BIT = 8;
  localparam int F_BIT  = 7;
  localparam int NO_BIT = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int J_LT   = 2;
  localparam int J_EQ   = 1;
  localparam int J_GT   = 0;

endpackage

// File: rtl/alu.sv
// Hack ALU, purely combinational.
// Ports: x, y       16-bit operands
//        zx,nx,zy,ny,f,no  control bits
//        out        16-bit result
//        zr, ng     result-is-zero / result-is-negative flags
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x1, x2, y1, y2, r;

  always_comb begin
    x1  = zx ? '0 : x;
    x2  = nx ? ~x1 : x1;
    y1  = zy ? '0 : y;
    y2  = ny ? ~y1 : y1;
    r   = f ? (x2 + y2) : (x2 & y2);
    out = no ? ~r : r;
    zr  = (out == '0);
    ng  = out[15];
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control and register stage around the Hack ALU.
// Fetches via imem req/ack, decodes A/C instructions, reads M and writes
// M via dmem req/ack, and updates A, D and PC.
// Ports: clk, rst_n (async active-low)
//        imem_req/imem_addr/imem_rdata/imem_ack   instruction fetch port
//        dmem_re/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_ack  data port
//        retire     one-cycle pulse in the final cycle of each instruction
//        pc, a_reg, d_reg  architectural registers (debug)
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              retire,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] d_reg
);

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] m_reg;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] maddr_q;

  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zr;
  logic              alu_ng;
  logic              jump;

  always_comb begin
    alu_y = ir[A_BIT] ? m_reg : a_q;
    jump  = (ir[J_LT] & alu_ng) |
            (ir[J_EQ] & alu_zr) |
            (ir[J_GT] & ~alu_ng & ~alu_zr);
  end

  alu u_alu (
    .x  (d_q),
    .y  (alu_y),
    .zx (ir[ZX_BIT]),
    .nx (ir[NX_BIT]),
    .zy (ir[ZY_BIT]),
    .ny (ir[NY_BIT]),
    .f  (ir[F_BIT]),
    .no (ir[NO_BIT]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ir      <= '0;
      m_reg   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      maddr_q <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (!ir[CI_BIT]) begin
            a_q   <= {1'b0, ir[ADDR_W-1:0]};
            pc_q  <= pc_q + 1'b1;
            state <= FETCH;
          end else if (ir[A_BIT]) begin
            state <= MREAD;
          end else begin
            state <= EXEC;
          end
        end
        MREAD: begin
          if (dmem_ack) begin
            m_reg <= dmem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Jump target and M address both use A as it was before this edge.
          if (ir[DEST_A]) a_q <= alu_out;
          if (ir[DEST_D]) d_q <= alu_out;
          pc_q <= jump ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
          if (ir[DEST_M]) begin
            maddr_q <= a_q[ADDR_W-1:0];
            wdata_q <= alu_out;
            state   <= MWRITE;
          end else begin
            state <= FETCH;
          end
        end
        MWRITE: begin
          if (dmem_ack) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly so an asynchronous reset
  // drops any outstanding request immediately.
  always_comb begin
    imem_req   = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    retire     = 1'b0;
    case (state)
      FETCH:  imem_req = 1'b1;
      DECODE: retire = ~ir[CI_BIT];
      MREAD: begin
        dmem_re   = 1'b1;
        dmem_addr = a_q[ADDR_W-1:0];
      end
      EXEC:   retire = ~ir[DEST_M];
      MWRITE: begin
        dmem_we    = 1'b1;
        dmem_addr  = maddr_q;
        dmem_wdata = wdata_q;
        retire     = dmem_ack;
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign a_reg     = a_q;
  assign d_reg     = d_q;

endmodule
